// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds state encodings, requester count/select width and the default tenure bound.
package mux_arb_pkg;

    localparam int N_REQ        = 4;
    localparam int SEL_W        = 2;
    localparam int HOLD_MAX_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters and the mux arbiter.
// MUX_ARB_LOCK_EN adds the lock input that pins the current grant past HOLD_MAX.
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] in;
    logic [SEL_W-1:0] sel;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             out;
`ifdef MUX_ARB_LOCK_EN
    logic             lock;

    modport master (output req, in, lock, input sel, grant, busy, out);
    modport slave  (input req, in, lock, output sel, grant, busy, out);
`else
    modport master (output req, in, input sel, grant, busy, out);
    modport slave  (input req, in, output sel, grant, busy, out);
`endif
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, ptr itself last.
// Zero latency; no flow control.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan farthest-first so the nearest candidate after ptr overwrites the rest.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux; grant follows req by one cycle.
// Tenure bounded by HOLD_MAX (bypassed by lock under MUX_ARB_LOCK_EN); no pre-emption.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] pick;
    logic             any;
    logic             cur_req;
    logic             at_limit;
    logic             lock_hold;
    logic             release_now;

    // ptr always equals the current owner while granted, so the releasing requester is scanned last.
    rr_pick u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    assign cur_req  = bus.req[sel_q];
    assign at_limit = (hold_q == HOLD_LAST);
`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = bus.lock & cur_req;
`else
    assign lock_hold = 1'b0;
`endif
    assign release_now = !cur_req || (at_limit && !lock_hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= 2'b11;
            hold_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick;
                    ptr_d   = pick;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (!release_now) begin
                    // Only reachable at the limit when locked: saturate instead of wrapping.
                    hold_d = at_limit ? hold_q : hold_q + 8'd1;
                end else if (any) begin
                    sel_d  = pick;
                    ptr_d  = pick;
                    hold_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_GRANT);
        grant_d = busy_d ? (N_REQ'(1) << sel_d) : '0;
    end

    always_comb begin
        bus.sel   = sel_q;
        bus.grant = grant_q;
        bus.busy  = busy_q;
        bus.out   = busy_q ? bus.in[sel_q] : 1'b0;
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: expected grant/sel/busy per cycle are queued, then popped each cycle.
module tb_mux_rr_arbiter;
    import mux_arb_pkg::*;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    mux_rr_arbiter_if bus();

    mux_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic push_grant(input logic [1:0] s, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            sb.push_back('{grant: 4'b0001 << s, sel: s, busy: 1'b1});
        end
    endtask

    task automatic push_idle(input logic [1:0] s);
        sb.push_back('{grant: 4'b0000, sel: s, busy: 1'b0});
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
        bus.in  = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.in  = 4'b1111;
`ifdef MUX_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
        n_tests++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++;
        if (bus.sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b want 00", bus.sel); end
        n_tests++;
        if (bus.out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b want 0", bus.out); end
        rst = 1'b0;
        push_grant(2'd0, 1);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL reset_first_grant: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
        n_tests++;
        if (bus.out !== 1'b1) begin n_fail++; $display("FAIL reset_out_granted: got %b want 1", bus.out); end
    endtask

    task automatic test_fairness();
        exp_t e;
        do_reset();
        bus.req = 4'b1111;
        push_grant(2'd0, 8);
        push_grant(2'd1, 8);
        push_grant(2'd2, 8);
        push_grant(2'd3, 8);
        push_grant(2'd0, 8);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL fairness: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        bus.req = 4'b1010;
        push_grant(2'd1, 8);
        push_grant(2'd3, 8);
        push_grant(2'd1, 2);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL back_to_back: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
    endtask

    task automatic test_early_release();
        exp_t e;
        do_reset();
        bus.req = 4'b0101;
        push_grant(2'd0, 3);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL early_hold: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
        bus.req = 4'b0100;
        push_grant(2'd2, 1);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL early_release: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
        bus.in = 4'b0100;
        #1;
        n_tests++;
        if (bus.out !== 1'b1) begin n_fail++; $display("FAIL early_out_hi: got %b want 1", bus.out); end
        bus.in = 4'b1011;
        #1;
        n_tests++;
        if (bus.out !== 1'b0) begin n_fail++; $display("FAIL early_out_lo: got %b want 0", bus.out); end
    endtask

    task automatic test_sole_requester();
        exp_t e;
        do_reset();
        bus.req = 4'b0010;
        push_grant(2'd1, 8);
        push_grant(2'd1, 3);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL sole_regrant: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
        bus.req = 4'b0000;
        push_idle(2'd1);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL sole_idle: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        bus.req = 4'b1000;
        bus.in  = 4'b1000;
        push_grant(2'd3, 2);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL async_pre: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.grant, bus.busy, bus.out} !== 6'b0000_0_0) begin
            n_fail++;
            $display("FAIL async_clear: got grant=%b busy=%b out=%b want 0000/0/0", bus.grant, bus.busy, bus.out);
        end
        bus.req = 4'b1001;
        @(negedge clk);
        rst = 1'b0;
        push_grant(2'd0, 1);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL async_post: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        exp_t e;
        do_reset();
        bus.lock = 1'b1;
        bus.req  = 4'b0011;
        push_grant(2'd0, 12);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL lock_hold: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
        bus.lock = 1'b0;
        push_grant(2'd1, 1);
        while (sb.size() > 0) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            n_tests++;
            if ({bus.grant, bus.sel, bus.busy} !== e) begin
                n_fail++;
                $display("FAIL lock_release: got grant=%b sel=%b busy=%b want grant=%b sel=%b busy=%b",
                         bus.grant, bus.sel, bus.busy, e.grant, e.sel, e.busy);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_back_to_back();
        test_early_release();
        test_sole_requester();
        test_async_reset();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 bit-select multiplexer path among four requesters.
- Each requester i raises req[i]; the block drives the mux select, a one-hot grant and the muxed output bit.
- A hold counter bounds grant tenure so no requester can starve the others.
- Sits directly in front of the behavioural 4:1 mux datapath and replaces a static sel driver.

Parameters:
- N_REQ, 4: number of requesters; fixed at 4 (sel is 2 bits). Other values are not supported.
- SEL_W, 2: select width, log2(N_REQ).
- HOLD_MAX, 8: maximum consecutive cycles one grant may last; legal range 1..255.

Ports:
- clk  in  1  single rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  4  request vector; req[i] = requester i wants the mux
- in  in  4  data bits; in[i] belongs to requester i
- sel  out  2  registered mux select (index of granted requester)
- grant  out  4  registered one-hot grant; 4'b0000 when idle
- busy  out  1  registered; 1 while any grant is active
- out  out  1  combinational; busy ? in[sel] : 1'b0

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=2'b00, grant=4'b0000, busy=0, hold_cnt=0, ptr=2'b11. With ptr=3, requester 0 has first priority; out=0.
- States: IDLE, GRANT.
- Pick function: first i with req[i]=1, searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
- IDLE:
  - req==0: stay.
  - Otherwise, at the next edge: state=GRANT, sel=pick, grant=1<<pick, busy=1, ptr=pick, hold_cnt=0.
  - Latency: req sampled at edge t produces grant visible after edge t+1 (one cycle).
- GRANT, each edge:
  - req[sel]=1 and hold_cnt<HOLD_MAX-1: hold; hold_cnt+=1.
  - Release when req[sel]=0 OR hold_cnt==HOLD_MAX-1:
    - If any req bit is set (the releasing bit included only if still high): re-pick from the updated ptr with no idle cycle. Load sel, grant, ptr and hold_cnt=0.
    - Else: go to IDLE with grant=0, busy=0, sel unchanged.
  - The releasing requester has the lowest priority on re-pick. If it is the only requester left it is re-granted back-to-back.
- hold_cnt: 8-bit unsigned; never exceeds HOLD_MAX-1; no wrap.
- Requests from other requesters arriving mid-tenure never pre-empt the current grant.
- grant is always one-hot or zero, and grant==(busy<<sel).
- Reset asserted mid-tenure clears everything immediately (async); the first pick after reset again favours requester 0.
- in changes propagate to out combinationally while busy.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined: adds input port lock (1 bit). While GRANT and lock=1 and req[sel]=1, the HOLD_MAX release is suppressed; hold_cnt saturates at HOLD_MAX-1. Dropping req[sel] still releases. lock is ignored in IDLE.
- Undefined: no lock port; HOLD_MAX release is unconditional.

Decomposition:
- Shared package/include (mux_arb_pkg):
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - N_REQ and SEL_W constants.
  - Default HOLD_MAX.
- One sub-module: rr_pick. Combinational; inputs req[3:0] and ptr[1:0]; outputs pick[1:0] and any. Instantiated once and used by both states.
- The output mux is written inline as in[sel] gated by busy.

Test Plan:
- Reset: rst=1 with req=4'b1111 -> grant=0000, busy=0, sel=00, out=0. Release rst, next edge -> grant=0001, sel=00.
- Fairness: req=4'b1111 held, HOLD_MAX=8 -> each requester gets 8 cycles in order 0,1,2,3,0, with no idle gaps.
- Early release: req=4'b0101 granted to 0; drop req[0] after 3 cycles -> next edge grant=0100, sel=10. Set in=4'b0100 -> out=1.
- Sole requester: req=4'b0010 only, HOLD_MAX=8 -> 8-cycle tenure, then immediate re-grant to 1, busy stays 1. Drop req -> IDLE next edge, grant=0000.
- Async reset mid-tenure: assert rst between edges while sel=11 -> grant=0000, busy=0 immediately. After release with req=4'b1001 -> grant=0001.
- MUX_ARB_LOCK_EN: lock=1, req=4'b0011 granted to 0 -> tenure exceeds 8 cycles. Drop lock -> release at the next edge to requester 1.
